// File: rtl/serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl
//
// Bit-serial ALU with a small IDLE/RUN/DONE controller. One operand bit is
// processed per RUN cycle, LSB first, so an operation takes WIDTH cycles of
// RUN followed by a single DONE cycle in which the registered result is new.
//
// Operation select (op):
//   op[2]    inverts operand b and forces the bit-0 carry-in to 1
//   op[1:0]  00 AND, 01 OR, 10 SUM, 11 LESS (sign of a + ~b + 1)
//
// Parameters:
//   WIDTH    operand/result width in bits, 2..64
//
// Ports:
//   clk      input   rising-edge clock
//   reset    input   asynchronous, active-high reset
//   start    input   request a new operation (ignored while busy)
//   op       input   [2:0] operation select, latched on accepted start
//   a, b     input   [WIDTH-1:0] operands, latched on accepted start
//   busy     output  high while bits are being processed (RUN)
//   done     output  one-cycle pulse when result becomes valid (DONE)
//   result   output  [WIDTH-1:0] registered result, held until next completion
//   zero     output  result is all zeros (registered with result)
//   c_out    output  carry out of bit WIDTH-1 (registered with result)
//   overflow output  only when SERIAL_ALU_OVF_EN is defined: carry-in XOR
//                    carry-out of bit WIDTH-1 for SUM/LESS, 0 otherwise
//
// Configuration:
//   SERIAL_ALU_OVF_EN  define to add the overflow output and its register.
// ---------------------------------------------------------------------------
module serial_alu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             c_out
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] OpAnd  = 2'b00;
    localparam logic [1:0] OpOr   = 2'b01;
    localparam logic [1:0] OpSum  = 2'b10;
    localparam logic [1:0] OpLess = 2'b11;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [CntW-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       op_q,     op_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             c_out_q,  c_out_d;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    // -----------------------------------------------------------------------
    // One-bit datapath slice, evaluated on the bit selected by the counter
    // -----------------------------------------------------------------------
    logic bit_a;
    logic bit_b;
    logic bit_and;
    logic bit_or;
    logic bit_sum;
    logic bit_cout;
    logic bit_sel;
    logic last_bit;

    always_comb begin
        bit_a    = a_q[cnt_q];
        bit_b    = b_q[cnt_q] ^ op_q[2];
        bit_and  = bit_a & bit_b;
        bit_or   = bit_a | bit_b;
        bit_sum  = bit_a ^ bit_b ^ carry_q;
        bit_cout = (bit_a & bit_b) | ((bit_a ^ bit_b) & carry_q);
        last_bit = (cnt_q == CntW'(WIDTH - 1));

        bit_sel = 1'b0;
        unique case (op_q[1:0])
            OpAnd:   bit_sel = bit_and;
            OpOr:    bit_sel = bit_or;
            OpSum:   bit_sel = bit_sum;
            OpLess:  bit_sel = 1'b0;
            default: bit_sel = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        c_out_d  = c_out_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op[2];
                    acc_d   = '0;
                end
            end

            StRun: begin
                // Each bit lands at its final position, so after WIDTH cycles
                // acc holds the whole word with bit 0 first in time.
                acc_d[cnt_q] = bit_sel;
                carry_d      = bit_cout;
                cnt_d        = last_bit ? '0 : cnt_q + CntW'(1);

                if (last_bit) begin
                    state_d = StDone;
                    if (op_q[1:0] == OpLess) begin
                        // LESS reports only the sign of a + ~b + 1.
                        result_d = {{(WIDTH - 1){1'b0}}, bit_sum};
                    end else begin
                        result_d = acc_d;
                    end
                    zero_d  = ~|result_d;
                    c_out_d = bit_cout;
`ifdef SERIAL_ALU_OVF_EN
                    // Arithmetic ops only: op[1] is set for SUM and LESS.
                    ovf_d   = op_q[1] & (carry_q ^ bit_cout);
`endif
                end
            end

            StDone: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op[2];
                    acc_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            c_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            c_out_q  <= c_out_d;
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign zero   = zero_q;
    assign c_out  = c_out_q;

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only when not busy.
REQ-005 SHALL have port: op  input  3  op[2] inverts b and sets bit-0 carry-in; op[1:0] selects 00 AND, 01 OR, 10 SUM, 11 LESS.
REQ-006 SHALL have port: a  input  WIDTH  operand A, captured on accepted start.
REQ-007 SHALL have port: b  input  WIDTH  operand B, captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when result becomes valid.
REQ-010 SHALL have port: result  output  WIDTH  registered result, held until the next accepted start completes.
REQ-011 SHALL have port: zero  output  1  high when result is all zeros; registered with result.
REQ-012 SHALL have port: c_out  output  1  carry out of bit WIDTH-1; registered with result.

Function
REQ-013 SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL accept start in IDLE or DONE; on acceptance it latches a, b and op, clears the bit counter, sets the carry to op[2], and enters RUN.
REQ-015 SHALL ignore start while in RUN; latched operands and op SHALL NOT change.
REQ-016 SHALL process exactly one bit per RUN cycle, LSB first, for WIDTH cycles.
REQ-017 SHALL compute per bit: bb = b[i] XOR op[2]; and = a&bb; or = a|bb; sum = a^bb^cin; cout = a&bb | (a^bb)&cin.
REQ-018 SHALL shift the selected bit (AND/OR/SUM; 0 for LESS) into the result shift register and carry cout to the next bit.
REQ-019 SHALL for LESS substitute {WIDTH-1 zeros, sum of bit WIDTH-1} as the final result; e.g. op=111 yields signed a<b without overflow correction.
REQ-020 SHALL move from RUN to DONE after the cycle that processes bit WIDTH-1 (counter wrap to 0).
REQ-021 SHALL hold busy=1 from the edge that accepts start through the edge that processes the last bit.
REQ-022 SHALL assert done for exactly one cycle, in the cycle after the last bit: start sampled at edge E0 gives done=1 between E(WIDTH) and E(WIDTH+1).
REQ-023 SHALL update result, zero and c_out only at the transition into DONE.
REQ-024 SHALL, with start high in DONE, restart immediately: done=1 and busy=0 that cycle, busy=1 the next cycle.
REQ-025 SHALL move from DONE to IDLE when start is low.
REQ-026 SHALL give undefined-free behaviour for all 8 op codes per REQ-017..019; no opcode is illegal.

Reset
REQ-027 SHALL, on reset assertion at any time including mid-RUN, immediately enter IDLE and clear busy=0, done=0, result=0, c_out=0, counter and carry; zero SHALL reset to 1.
REQ-028 SHALL discard any in-flight operation on reset; no done pulse follows it.
REQ-029 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with SERIAL_ALU_OVF_EN defined, add output port overflow (1 bit), equal to carry-in XOR carry-out of bit WIDTH-1 for SUM/LESS ops and 0 otherwise; registered with result, reset to 0.
REQ-031 SHALL, without SERIAL_ALU_OVF_EN, have no overflow port and no overflow logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: WIDTH=32, op=010, a=0x0000_0005, b=0x0000_0003, start one cycle -> busy 32 cycles, done at cycle 33, result=0x8, zero=0, c_out=0.
REQ-033 SHALL cover: op=110, a=b=0x1234_5678 -> result=0, zero=1, c_out=1.
REQ-034 SHALL cover: op=111, a=0xFFFF_FFFF (-1), b=0x1 -> result=0x1; swapped operands -> result=0x0.
REQ-035 SHALL cover: op=000 then 001 back-to-back (start held high through done), a=0xF0F0_F0F0, b=0xFF00_FF00 -> 0xF000_F000 then 0xFFF0_FFF0, no idle cycle between ops.
REQ-036 SHALL cover: start pulsed again at bit 10 with different operands, then reset at bit 20 of a second op -> first result unaffected; after reset busy=0, done never pulses, result=0, zero=1.
REQ-037 SHALL cover (SERIAL_ALU_OVF_EN): op=010, a=0x7FFF_FFFF, b=0x1 -> result=0x8000_0000, overflow=1; op=000 -> overflow=0.
